vga_clock_digits: RTL and testbench

- Pixel-pipeline stage directly downstream of the VGA sync generator (640x480@72Hz, 31.5 MHz pixel clock).
- Consumes the generator's sync, active-video and pixel-coordinate outputs and renders HH:MM:SS as seven-segment glyphs.
- Drives 3-bit RGB plus re-aligned hsync/vsync to the VGA pins.
- The time value is latched once per frame so a frame never shows a mixed time.

---
 rtl/vga_clock_digits.sv | 191 +++++++++++++++++++
 tb/tb_vga_clock_digits.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_clock_digits.sv
// Seven-segment HH:MM:SS overlay stage placed after the VGA sync generator.
// Realigns the syncs to the coordinates, renders the time glyphs and latches the time once per frame.
module vga_clock_digits #(
  parameter int       X0       = 64,
  parameter int       Y0       = 176,
  parameter logic [2:0] FG     = 3'b010,
  parameter logic [2:0] BG     = 3'b000,
  parameter bit       BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        activevideo_in,
  input  logic [9:0]  x_px,
  input  logic [9:0]  y_px,
  input  logic [23:0] time_bcd,
  input  logic        colon_on,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  rgb
);

  localparam logic [9:0] X0_V = X0[9:0];
  localparam logic [9:0] Y0_V = Y0[9:0];

  // Segment rectangles for a..g (index 0 = a), half-open [lo,hi) in glyph-cell pixels.
  localparam logic [6:0] SEG_XL [7] = '{7'd16, 7'd48, 7'd48,  7'd16,  7'd8,   7'd8,  7'd16};
  localparam logic [6:0] SEG_XH [7] = '{7'd48, 7'd56, 7'd56,  7'd48,  7'd16,  7'd16, 7'd48};
  localparam logic [6:0] SEG_YL [7] = '{7'd8,  7'd16, 7'd68,  7'd112, 7'd68,  7'd16, 7'd60};
  localparam logic [6:0] SEG_YH [7] = '{7'd16, 7'd60, 7'd112, 7'd120, 7'd112, 7'd60, 7'd68};

  // Stage A: syncs delayed one cycle so they describe the same pixel as x_px/y_px.
  logic        hs_a_q, vs_a_q, av_a_q, vs_prev_q;
  logic [23:0] time_sh_q;
  logic        colon_sh_q;
  logic        frame_start_d;

  assign frame_start_d = vs_prev_q & ~vs_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_a_q     <= 1'b1;
      vs_a_q     <= 1'b1;
      av_a_q     <= 1'b0;
      vs_prev_q  <= 1'b1;
      time_sh_q  <= 24'h000000;
      colon_sh_q <= 1'b0;
    end else begin
      hs_a_q    <= hsync_in;
      vs_a_q    <= vsync_in;
      av_a_q    <= activevideo_in;
      vs_prev_q <= vs_a_q;
      if (frame_start_d) begin
        time_sh_q  <= time_bcd;
        colon_sh_q <= colon_on;
      end
    end
  end

  // S1: locate the pixel inside the digit row; wrap-around of the subtracts rejects pixels left/above.
  logic [9:0] dx_d, dy_d;
  logic       in_win_d;

  assign dx_d     = x_px - X0_V;
  assign dy_d     = y_px - Y0_V;
  assign in_win_d = (dx_d < 10'd512) && (dy_d < 10'd128);

  logic       hs1_q, vs1_q, av1_q, win1_q;
  logic [2:0] slot1_q;
  logic [5:0] lx1_q;
  logic [6:0] ly1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      av1_q   <= 1'b0;
      win1_q  <= 1'b0;
      slot1_q <= 3'd0;
      lx1_q   <= 6'd0;
      ly1_q   <= 7'd0;
    end else begin
      hs1_q   <= hs_a_q;
      vs1_q   <= vs_a_q;
      av1_q   <= av_a_q;
      win1_q  <= in_win_d;
      slot1_q <= dx_d[8:6];
      lx1_q   <= dx_d[5:0];
      ly1_q   <= dy_d[6:0];
    end
  end

  // S2: pick the digit for this slot from the frame-stable shadow and test the segment hit.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] m;
    case (n)
      4'd0:    m = 7'b1111110;
      4'd1:    m = 7'b0110000;
      4'd2:    m = 7'b1101101;
      4'd3:    m = 7'b1111001;
      4'd4:    m = 7'b0110011;
      4'd5:    m = 7'b1011011;
      4'd6:    m = 7'b1011111;
      4'd7:    m = 7'b1110000;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1111011;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

  logic [3:0] nib_d;
  logic       is_colon_d;
  logic       blank_d;
  logic [6:0] mask_d;
  logic [6:0] seg_hit_d;
  logic       colon_hit_d;
  logic       lit2_d;
  logic [6:0] lx_ext_d;

  always_comb begin
    nib_d      = 4'hF;
    is_colon_d = 1'b0;
    case (slot1_q)
      3'd0:    nib_d = time_sh_q[23:20];
      3'd1:    nib_d = time_sh_q[19:16];
      3'd3:    nib_d = time_sh_q[15:12];
      3'd4:    nib_d = time_sh_q[11:8];
      3'd6:    nib_d = time_sh_q[7:4];
      3'd7:    nib_d = time_sh_q[3:0];
      default: is_colon_d = 1'b1;
    endcase
  end

  assign blank_d  = (BLANK_LZ != 1'b0) && (slot1_q == 3'd0) && (nib_d == 4'd0);
  assign mask_d   = blank_d ? 7'b0000000 : seg_decode(nib_d);
  assign lx_ext_d = {1'b0, lx1_q};

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_seg
      assign seg_hit_d[6-gi] = (lx_ext_d >= SEG_XL[gi]) && (lx_ext_d < SEG_XH[gi]) &&
                               (ly1_q >= SEG_YL[gi]) && (ly1_q < SEG_YH[gi]);
    end
  endgenerate

  assign colon_hit_d = (lx_ext_d >= 7'd28) && (lx_ext_d < 7'd36) &&
                       (((ly1_q >= 7'd40) && (ly1_q < 7'd48)) ||
                        ((ly1_q >= 7'd80) && (ly1_q < 7'd88)));

  assign lit2_d = win1_q && (is_colon_d ? (colon_sh_q && colon_hit_d)
                                        : (|(mask_d & seg_hit_d)));

  logic hs2_q, vs2_q, av2_q, lit2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      av2_q  <= 1'b0;
      lit2_q <= 1'b0;
    end else begin
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      av2_q  <= av1_q;
      lit2_q <= lit2_d;
    end
  end

  // S3: colour and pin-aligned syncs all leave on the same edge.
  logic       hs3_q, vs3_q;
  logic [2:0] rgb3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs3_q  <= 1'b1;
      vs3_q  <= 1'b1;
      rgb3_q <= 3'b000;
    end else begin
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      rgb3_q <= av2_q ? (lit2_q ? FG : BG) : 3'b000;
    end
  end

  assign hsync = hs3_q;
  assign vsync = vs3_q;
  assign rgb   = rgb3_q;

endmodule

// File: tb/tb_vga_clock_digits.sv
// Bench for vga_clock_digits: directed vector table, corner sequences and a random run,
// all scored against a per-cycle behavioural model of the overlay.
module tb_vga_clock_digits;

  localparam int X0 = 64;
  localparam int Y0 = 176;
  localparam logic [2:0] FG = 3'b010;
  localparam logic [2:0] BG = 3'b000;
  localparam bit BLANK_LZ = 1'b1;
  localparam int MAXE = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        activevideo_in = 1'b0;
  logic [9:0]  x_px = '0;
  logic [9:0]  y_px = '0;
  logic [23:0] time_bcd = '0;
  logic        colon_on = 1'b0;
  logic        hsync, vsync;
  logic [2:0]  rgb;

  vga_clock_digits #(
    .X0(X0), .Y0(Y0), .FG(FG), .BG(BG), .BLANK_LZ(BLANK_LZ)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .activevideo_in(activevideo_in), .x_px(x_px), .y_px(y_px),
    .time_bcd(time_bcd), .colon_on(colon_on),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Input history per clock edge plus the model's frame-latched time after that edge.
  logic        h_rst [MAXE];
  logic        h_hs  [MAXE];
  logic        h_vs  [MAXE];
  logic        h_av  [MAXE];
  int          h_x   [MAXE];
  int          h_y   [MAXE];
  logic [23:0] h_t   [MAXE];
  logic        h_c   [MAXE];
  logic [23:0] m_t   [MAXE];
  logic        m_c   [MAXE];
  int          ne = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  string       seg_of [10];

  typedef struct {
    int         slot;
    int         lx;
    int         ly;
    logic [2:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic bit in_seg(input byte s, input int lx, input int ly);
    case (s)
      "a": return rng(ly, 8, 16) && rng(lx, 16, 48);
      "g": return rng(ly, 60, 68) && rng(lx, 16, 48);
      "d": return rng(ly, 112, 120) && rng(lx, 16, 48);
      "f": return rng(lx, 8, 16) && rng(ly, 16, 60);
      "b": return rng(lx, 48, 56) && rng(ly, 16, 60);
      "e": return rng(lx, 8, 16) && rng(ly, 68, 112);
      "c": return rng(lx, 48, 56) && rng(ly, 68, 112);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_lit(input int x, input int y, input logic [23:0] t, input logic c);
    int slot, lx, ly, di, nib;
    string s;
    if (x < X0 || x >= X0 + 512 || y < Y0 || y >= Y0 + 128) return 1'b0;
    slot = (x - X0) / 64;
    lx   = (x - X0) % 64;
    ly   = y - Y0;
    if (slot == 2 || slot == 5)
      return c && rng(lx, 28, 36) && (rng(ly, 40, 48) || rng(ly, 80, 88));
    di  = slot - slot / 3;
    nib = int'((t >> (20 - 4 * di)) & 24'hF);
    if (nib > 9) return 1'b0;
    if (di == 0 && nib == 0 && BLANK_LZ) return 1'b0;
    s = seg_of[nib];
    for (int i = 0; i < s.len(); i++)
      if (in_seg(s[i], lx, ly)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic vs_eff(input int e);
    if (e < 0) return 1'b1;
    return h_rst[e] ? 1'b1 : h_vs[e];
  endfunction

  function automatic bit rst_at(input int e);
    if (e < 0) return 1'b1;
    return h_rst[e];
  endfunction

  // One clock edge: record inputs, advance the model, then compare all outputs.
  task automatic tick();
    logic [4:0] exp;
    if (ne >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", ne, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    @(posedge clk);
    h_rst[ne] = rst;      h_hs[ne] = hsync_in; h_vs[ne] = vsync_in;
    h_av[ne]  = activevideo_in;
    h_x[ne]   = int'(x_px); h_y[ne] = int'(y_px);
    h_t[ne]   = time_bcd; h_c[ne]  = colon_on;
    if (rst) begin
      m_t[ne] = '0; m_c[ne] = 1'b0;
    end else if (vs_eff(ne - 2) && !vs_eff(ne - 1)) begin
      m_t[ne] = time_bcd; m_c[ne] = colon_on;
    end else begin
      m_t[ne] = (ne > 0) ? m_t[ne - 1] : '0;
      m_c[ne] = (ne > 0) ? m_c[ne - 1] : 1'b0;
    end
    #1;
    if (rst_at(ne) || rst_at(ne - 1) || rst_at(ne - 2) || rst_at(ne - 3)) begin
      exp = 5'b11000;
    end else begin
      exp[4]   = h_hs[ne - 3];
      exp[3]   = h_vs[ne - 3];
      exp[2:0] = !h_av[ne - 3] ? 3'b000 :
                 (model_lit(h_x[ne - 2], h_y[ne - 2], m_t[ne - 2], m_c[ne - 2]) ? FG : BG);
    end
    check($sformatf("pipe@%0d", ne), 32'({hsync, vsync, rgb}), 32'(exp));
    ne++;
  endtask

  // Present one active pixel with the generator's skew; returns the rendered colour.
  task automatic show(input int x, input int y, output logic [2:0] got);
    activevideo_in = 1'b1;
    tick();
    activevideo_in = 1'b0;
    x_px = 10'(x);
    y_px = 10'(y);
    tick();
    tick();
    tick();
    got = rgb;
  endtask

  task automatic show_cell(input string name, input int slot, input int lx, input int ly,
                           input logic [2:0] exp);
    logic [2:0] got;
    show(X0 + slot * 64 + lx, Y0 + ly, got);
    $display("%s slot=%0d lx=%0d ly=%0d rgb=%0b", name, slot, lx, ly, got);
    check(name, 32'(got), 32'(exp));
  endtask

  task automatic frame(input logic [23:0] t, input logic c);
    time_bcd = t;
    colon_on = c;
    vsync_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   dslots[6];
    vec_t v;
    logic [2:0] cexp;

    seg_of = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    dslots = '{0, 1, 3, 4, 6, 7};
    foreach (dslots[i]) begin
      tbl.push_back('{dslots[i], 20, 10, FG});
      tbl.push_back('{dslots[i], 50, 30, FG});
      tbl.push_back('{dslots[i], 12, 90, FG});
      tbl.push_back('{dslots[i], 30, 64, FG});
      tbl.push_back('{dslots[i], 30, 30, BG});
      tbl.push_back('{dslots[i], 4, 4, BG});
    end
    for (int s = 2; s <= 5; s += 3) begin
      tbl.push_back('{s, 30, 44, FG});
      tbl.push_back('{s, 30, 64, BG});
    end

    // Reset state
    rst = 1'b1;
    tick(); tick(); tick();
    check("reset_rgb", 32'(rgb), 32'(3'b000));
    check("reset_sync", 32'({hsync, vsync}), 32'(2'b11));
    rst = 1'b0;
    tick(); tick(); tick(); tick();

    // Latency and alignment
    frame(24'h800000, 1'b0);
    tick();
    hsync_in = 1'b0;
    activevideo_in = 1'b1;
    tick();
    activevideo_in = 1'b0;
    x_px = 10'(X0 + 20);
    y_px = 10'(Y0 + 10);
    tick();
    check("lat_hs_n1", 32'(hsync), 32'(1'b1));
    tick();
    check("lat_hs_n2", 32'(hsync), 32'(1'b1));
    hsync_in = 1'b1;
    tick();
    check("lat_hs_n3", 32'(hsync), 32'(1'b0));
    check("lat_rgb", 32'(rgb), 32'(FG));
    tick(); tick(); tick();

    // Digit 8 scan
    frame(24'h888888, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      show_cell($sformatf("scan%0d", i), v.slot, v.lx, v.ly, v.exp);
    end

    // Frame latch: a mid-frame time change waits for the next vsync
    frame(24'h123456, 1'b1);
    show_cell("latch_pre_e", 7, 12, 90, FG);
    time_bcd = 24'h123457;
    show_cell("latch_mid_e", 7, 12, 90, FG);
    show_cell("latch_mid_b", 7, 50, 30, BG);
    frame(24'h123457, 1'b1);
    show_cell("latch_next_e", 7, 12, 90, BG);
    show_cell("latch_next_b", 7, 50, 30, FG);

    // Invalid nibble and leading-zero blanking
    frame(24'h0A5959, 1'b0);
    show_cell("blank_h1_e", 0, 12, 90, BG);
    show_cell("blank_h1_a", 0, 20, 10, BG);
    show_cell("blank_h0_a", 1, 20, 10, BG);
    show_cell("blank_h0_g", 1, 30, 64, BG);
    show_cell("m1_5_a", 3, 20, 10, FG);
    show_cell("m1_5_b", 3, 50, 30, BG);
    show_cell("m0_9_b", 4, 50, 30, FG);
    show_cell("m0_9_e", 4, 12, 90, BG);
    show_cell("s1_5_f", 6, 12, 30, FG);
    show_cell("s0_9_d", 7, 30, 116, FG);

    // Colon blink: the colon follows the latched bit, not the live one
    for (int f = 0; f < 4; f++) begin
      cexp = (f % 2 == 0) ? FG : BG;
      frame(24'h123456, (f % 2 == 0));
      show_cell($sformatf("colon_f%0d", f), 2, 30, 44, cexp);
      colon_on = ~colon_on;
      show_cell($sformatf("colon_hold_f%0d", f), 5, 30, 84, cexp);
    end

    // Reset mid-line, then refill
    frame(24'h000000, 1'b0);
    hsync_in = 1'b0;
    activevideo_in = 1'b1;
    x_px = 10'(X0 + 64 + 20);
    y_px = 10'(Y0 + 10);
    tick(); tick(); tick(); tick();
    check("pre_reset_rgb", 32'(rgb), 32'(FG));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("in_reset%0d", i), 32'({hsync, vsync, rgb}), 32'(5'b11000));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("refill%0d", i), 32'({hsync, vsync, rgb}), 32'(5'b11000));
    end
    tick();
    check("refilled", 32'({hsync, vsync, rgb}), 32'({1'b0, 1'b1, FG}));
    hsync_in = 1'b1;
    activevideo_in = 1'b0;

    // Random run against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 399) == 0);
      hsync_in       = 1'($urandom_range(0, 1));
      vsync_in       = ($urandom_range(0, 15) != 0);
      activevideo_in = ($urandom_range(0, 3) != 0);
      x_px = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                         : 10'(X0 - 4 + int'($urandom_range(0, 520)));
      y_px = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                         : 10'(Y0 - 4 + int'($urandom_range(0, 136)));
      for (int n = 0; n < 6; n++) time_bcd[n*4 +: 4] = 4'($urandom_range(0, 11));
      colon_on = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    tick(); tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
